signal_analyser_mc: RTL and testbench
=====================================

Name: signal_analyser_mc

Overview:
Multi-channel successor to the single-channel audio signal analyser. It pops samples from the audio CODEC read FIFO using the read_ready/read handshake. Per channel, it tracks peak magnitude, zero-crossing count and loudness level over a measurement window delimited by an external tick (normally the 60 Hz counter output). At each tick it publishes registered per-window results for LED/HEX display.

Parameters:
DATA_W, 24, sample width per channel, signed two's complement
CHANNELS, 2, number of channels packed on sample_data (channel 0 in LSBs)
CNT_W, 15, width of the sample counter and zero-crossing counters
THRESH_LO, 24'h010000, magnitude below which a channel is "quiet"
THRESH_HI, 24'h200000, magnitude at or above which a channel is "loud"

Ports:
CLOCK_50  input  1  system clock; all state is on its rising edge
reset  input  1  synchronous, active-high reset
read_ready  input  1  CODEC has a sample pair available
sample_data  input  CHANNELS*DATA_W  CODEC read data, valid while read_ready=1
read  output  1  pop strobe to CODEC
enable  input  1  allow sample acceptance
window_tick  input  1  one-cycle pulse that closes the current window
peak  output  CHANNELS*DATA_W  per-channel peak magnitude of the last window
zero_cross  output  CHANNELS*CNT_W  per-channel sign-change count of the last window
level  output  CHANNELS*2  per-channel class: 00 quiet, 01 normal, 11 loud
sample_count  output  CNT_W  samples accepted in the last window
overflow  output  1  sample_count or any zero_cross saturated in the last window
result_valid  output  1  one-cycle pulse when results update

Behaviour:
- Handshake: read = read_ready & enable & ~reset (combinational).
  - A sample is accepted in any cycle with read=1; sample_data is captured that cycle.
  - There is never more than one accept per cycle.
- Magnitude per channel: |x|. The most negative value -2^(DATA_W-1) saturates to 2^(DATA_W-1)-1.
- Accumulators are internal and one set per channel:
  - acc_peak = max(acc_peak, |x|).
  - acc_zc increments when the sign bit differs from prev_sign[ch].
  - prev_sign is updated on every accept.
  - prev_sign persists across windows.
  - A first_seen flag suppresses counting on the first accept after reset.
- acc_cnt increments by 1 per accept.
- Counter saturation: all counters saturate at 2^CNT_W-1. Reaching saturation sets acc_ovf, which holds until the window closes.
- Window close happens on the cycle window_tick=1:
  - Outputs load from the accumulators on the next edge, so they are valid 1 cycle after the tick.
  - result_valid=1 for exactly that cycle.
  - Accumulators clear to 0.
- Tick coincident with an accept: the sample is included in the closing window's results. The new window starts empty.
- level is derived from each channel's latched peak at window close:
  - peak < THRESH_LO gives 00.
  - peak >= THRESH_HI gives 11.
  - Anything else gives 01.
- enable=0:
  - No accepts.
  - Ticks still close windows; an empty window reports peak=0, count=0, level=00.
  - prev_sign and first_seen are retained.
- Back-to-back ticks (consecutive cycles): each closes a window. The second reports an empty window unless an accept occurred between the two ticks.
- Reset (any cycle, including mid-window or coincident with a tick):
  - All outputs go to 0: read=0, result_valid=0, peak/zero_cross/level/sample_count/overflow=0.
  - Accumulators, prev_sign and first_seen are cleared.
  - A tick during reset is ignored.

Test Plan:
1. Reset, then enable=1 with read_ready held 1 for 10 cycles: ch0 alternating +0x100000/-0x100000, ch1 constant +0x300000. Tick.
   - Required next cycle: result_valid=1, sample_count=10.
   - ch0: peak=0x100000, zero_cross=9, level=01.
   - ch1: peak=0x300000, zero_cross=0, level=11.
2. Accept ch0=0x800000 (most negative), then tick.
   - Required: peak ch0=0x7FFFFF, level=11, no wrap.
3. Tick in the same cycle as the 5th accept of a window.
   - Required: closing result sample_count=5.
   - The following window, with 3 more accepts then a tick, reports 3.
4. CNT_W=4 build, 20 accepts with alternating sign, then tick.
   - Required: sample_count=15, zero_cross=15, overflow=1.
   - The next empty window reports overflow=0.
5. enable=0 with read_ready=1 for 50 cycles, then tick.
   - Required: read stays 0, sample_count=0, peak=0, level=00.
   - result_valid still pulses.
6. Assert reset mid-window after 7 accepts, coincident with a tick. Release reset, do 2 accepts (+1, -1), then tick.
   - Required: no result_valid during reset.
   - Next result: sample_count=2, zero_cross=1 (the first post-reset sample is not counted).

Source files
------------

// File: rtl/signal_analyser_mc_if.sv
// CODEC read-FIFO handshake bundle: sample pair presented with read_ready,
// popped by a one-cycle read strobe from the consumer.
interface signal_analyser_mc_if #(
    parameter int DATA_W   = 24,
    parameter int CHANNELS = 2
);
    logic                         read_ready;
    logic [CHANNELS*DATA_W-1:0]   sample_data;
    logic                         read;

    // CODEC / FIFO side
    modport master (
        output read_ready,
        output sample_data,
        input  read
    );

    // Analyser side
    modport slave (
        input  read_ready,
        input  sample_data,
        output read
    );
endinterface

// File: rtl/signal_analyser_mc.sv
// Multi-channel signal analyser: per-window peak magnitude, zero-crossing
// count and loudness class for each channel, published on window_tick.
module signal_analyser_mc #(
    parameter int                DATA_W    = 24,
    parameter int                CHANNELS  = 2,
    parameter int                CNT_W     = 15,
    parameter logic [DATA_W-1:0] THRESH_LO = 24'h010000,
    parameter logic [DATA_W-1:0] THRESH_HI = 24'h200000
) (
    input  logic                         CLOCK_50,
    input  logic                         reset,
    signal_analyser_mc_if.slave          codec,
    input  logic                         enable,
    input  logic                         window_tick,
    output logic [CHANNELS*DATA_W-1:0]   peak,
    output logic [CHANNELS*CNT_W-1:0]    zero_cross,
    output logic [CHANNELS*2-1:0]        level,
    output logic [CNT_W-1:0]             sample_count,
    output logic                         overflow,
    output logic                         result_valid
);

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [DATA_W-1:0] MAG_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] DATA_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic                                accept;
    logic [CHANNELS-1:0][DATA_W-1:0]     smp;
    logic [CHANNELS-1:0][DATA_W-1:0]     mag;
    logic [CHANNELS-1:0]                 sgn;

    // running accumulators for the open window
    logic [CHANNELS-1:0][DATA_W-1:0]     acc_peak_q, acc_peak_d;
    logic [CHANNELS-1:0][CNT_W-1:0]      acc_zc_q,   acc_zc_d;
    logic [CNT_W-1:0]                    acc_cnt_q,  acc_cnt_d;
    logic                                acc_ovf_q,  acc_ovf_d;

    // sign history survives window boundaries, only reset clears it
    logic [CHANNELS-1:0]                 prev_sign_q, prev_sign_d;
    logic                                first_seen_q, first_seen_d;

    // accumulator values including this cycle's accept (if any)
    logic [CHANNELS-1:0][DATA_W-1:0]     peak_upd;
    logic [CHANNELS-1:0][CNT_W-1:0]      zc_upd;
    logic [CNT_W-1:0]                    cnt_upd;
    logic                                ovf_upd;

    // published results
    logic [CHANNELS-1:0][DATA_W-1:0]     peak_q,         peak_d;
    logic [CHANNELS-1:0][CNT_W-1:0]      zero_cross_q,   zero_cross_d;
    logic [CHANNELS-1:0][1:0]            level_q,        level_d;
    logic [CNT_W-1:0]                    sample_count_q, sample_count_d;
    logic                                overflow_q,     overflow_d;
    logic                                result_valid_q, result_valid_d;

    // Pop strobe; reset gates it combinationally so nothing is lost during reset
    assign accept     = codec.read_ready & enable & ~reset;
    assign codec.read = accept;

    // Split the packed sample pair and form saturated magnitudes
    always_comb begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            smp[ch] = codec.sample_data[ch*DATA_W +: DATA_W];
            sgn[ch] = smp[ch][DATA_W-1];
            if (!sgn[ch]) begin
                mag[ch] = smp[ch];
            end else if (smp[ch] == DATA_MIN) begin
                // -2^(N-1) has no positive counterpart; clamp instead of wrapping
                mag[ch] = MAG_MAX;
            end else begin
                mag[ch] = ~smp[ch] + 1'b1;
            end
        end
    end

    // Fold the current accept into the accumulators (saturating counters)
    always_comb begin
        cnt_upd = acc_cnt_q;
        if (accept && (acc_cnt_q != CNT_MAX)) begin
            cnt_upd = acc_cnt_q + 1'b1;
        end
        ovf_upd      = acc_ovf_q | (cnt_upd == CNT_MAX);
        first_seen_d = first_seen_q | accept;
        prev_sign_d  = prev_sign_q;
        peak_upd     = acc_peak_q;
        zc_upd       = acc_zc_q;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            if (accept) begin
                prev_sign_d[ch] = sgn[ch];
                if (mag[ch] > acc_peak_q[ch]) begin
                    peak_upd[ch] = mag[ch];
                end
                // no previous sign exists for the very first sample after reset
                if (first_seen_q && (sgn[ch] != prev_sign_q[ch])
                    && (acc_zc_q[ch] != CNT_MAX)) begin
                    zc_upd[ch] = acc_zc_q[ch] + 1'b1;
                end
            end
            ovf_upd = ovf_upd | (zc_upd[ch] == CNT_MAX);
        end
    end

    // Window close: publish updated accumulators and start an empty window
    always_comb begin
        acc_peak_d     = peak_upd;
        acc_zc_d       = zc_upd;
        acc_cnt_d      = cnt_upd;
        acc_ovf_d      = ovf_upd;
        peak_d         = peak_q;
        zero_cross_d   = zero_cross_q;
        level_d        = level_q;
        sample_count_d = sample_count_q;
        overflow_d     = overflow_q;
        result_valid_d = 1'b0;
        if (window_tick) begin
            peak_d         = peak_upd;
            zero_cross_d   = zc_upd;
            sample_count_d = cnt_upd;
            overflow_d     = ovf_upd;
            result_valid_d = 1'b1;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                if (peak_upd[ch] < THRESH_LO) begin
                    level_d[ch] = 2'b00;
                end else if (peak_upd[ch] >= THRESH_HI) begin
                    level_d[ch] = 2'b11;
                end else begin
                    level_d[ch] = 2'b01;
                end
            end
            acc_peak_d = '0;
            acc_zc_d   = '0;
            acc_cnt_d  = '0;
            acc_ovf_d  = 1'b0;
        end
    end

    // State registers; reset takes priority over a coincident tick
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            acc_peak_q     <= '0;
            acc_zc_q       <= '0;
            acc_cnt_q      <= '0;
            acc_ovf_q      <= 1'b0;
            prev_sign_q    <= '0;
            first_seen_q   <= 1'b0;
            peak_q         <= '0;
            zero_cross_q   <= '0;
            level_q        <= '0;
            sample_count_q <= '0;
            overflow_q     <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            acc_peak_q     <= acc_peak_d;
            acc_zc_q       <= acc_zc_d;
            acc_cnt_q      <= acc_cnt_d;
            acc_ovf_q      <= acc_ovf_d;
            prev_sign_q    <= prev_sign_d;
            first_seen_q   <= first_seen_d;
            peak_q         <= peak_d;
            zero_cross_q   <= zero_cross_d;
            level_q        <= level_d;
            sample_count_q <= sample_count_d;
            overflow_q     <= overflow_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign peak         = peak_q;
    assign zero_cross   = zero_cross_q;
    assign level        = level_q;
    assign sample_count = sample_count_q;
    assign overflow     = overflow_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_signal_analyser_mc.sv
// Bench for signal_analyser_mc: two instances (CNT_W=15 and CNT_W=4) share
// one stimulus stream; a window-list model predicts every output each cycle.
module tb_signal_analyser_mc;

    localparam int DW = 24;
    localparam int CH = 2;

    logic            clk = 1'b0;
    logic            rst, rr, en, tick;
    logic [CH*DW-1:0] sdata;

    always #5 clk = ~clk;

    signal_analyser_mc_if #(.DATA_W(DW), .CHANNELS(CH)) bus_a ();
    signal_analyser_mc_if #(.DATA_W(DW), .CHANNELS(CH)) bus_b ();

    assign bus_a.read_ready  = rr;
    assign bus_a.sample_data = sdata;
    assign bus_b.read_ready  = rr;
    assign bus_b.sample_data = sdata;

    logic [CH*DW-1:0] peak_a, peak_b;
    logic [CH*15-1:0] zc_a;
    logic [CH*4-1:0]  zc_b;
    logic [CH*2-1:0]  lvl_a, lvl_b;
    logic [14:0]      cnt_a;
    logic [3:0]       cnt_b;
    logic             ovf_a, ovf_b, rv_a, rv_b;

    signal_analyser_mc #(.DATA_W(DW), .CHANNELS(CH), .CNT_W(15)) dut_a (
        .CLOCK_50(clk), .reset(rst), .codec(bus_a), .enable(en),
        .window_tick(tick), .peak(peak_a), .zero_cross(zc_a), .level(lvl_a),
        .sample_count(cnt_a), .overflow(ovf_a), .result_valid(rv_a)
    );

    signal_analyser_mc #(.DATA_W(DW), .CHANNELS(CH), .CNT_W(4)) dut_b (
        .CLOCK_50(clk), .reset(rst), .codec(bus_b), .enable(en),
        .window_tick(tick), .peak(peak_b), .zero_cross(zc_b), .level(lvl_b),
        .sample_count(cnt_b), .overflow(ovf_b), .result_valid(rv_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    logic [CH*DW-1:0] win[$];
    logic             m_prev[CH];
    bit               m_seen;
    bit               started = 0;
    logic [CH*DW-1:0] e_peak;
    logic [CH*2-1:0]  e_lvl;
    longint           e_raw_cnt;
    longint           e_raw_zc[CH];
    logic             e_rv;

    function automatic longint mag_of(input logic [DW-1:0] x);
        longint v;
        longint mx;
        v  = longint'($signed(x));
        mx = (longint'(1) << (DW-1)) - 1;
        if (v < 0) v = -v;
        if (v > mx) v = mx;
        return v;
    endfunction

    function automatic longint sat(input longint raw, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (raw > mx) ? mx : raw;
    endfunction

    function automatic logic ovf_of(input int w);
        longint mx;
        logic   o;
        mx = (longint'(1) << w) - 1;
        o  = (e_raw_cnt >= mx);
        for (int c = 0; c < CH; c++) if (e_raw_zc[c] >= mx) o = 1'b1;
        return o;
    endfunction

    task automatic close_window();
        e_raw_cnt = longint'(win.size());
        for (int c = 0; c < CH; c++) begin
            logic   p, s, sg;
            longint pk, zc, m;
            logic [DW-1:0] x;
            p = m_prev[c]; s = m_seen; pk = 0; zc = 0;
            foreach (win[i]) begin
                x  = win[i][c*DW +: DW];
                sg = x[DW-1];
                if (s && (sg != p)) zc++;
                p = sg; s = 1'b1;
                m = mag_of(x);
                if (m > pk) pk = m;
            end
            e_peak[c*DW +: DW] = DW'(pk);
            e_raw_zc[c]        = zc;
            if (pk < 64'h010000)       e_lvl[c*2 +: 2] = 2'b00;
            else if (pk >= 64'h200000) e_lvl[c*2 +: 2] = 2'b11;
            else                       e_lvl[c*2 +: 2] = 2'b01;
            m_prev[c] = p;
        end
        if (win.size() > 0) m_seen = 1'b1;
        win.delete();
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                win.delete();
                m_prev    = '{default: 1'b0};
                m_seen    = 1'b0;
                e_peak    = '0;
                e_lvl     = '0;
                e_raw_cnt = 0;
                e_raw_zc  = '{default: 0};
                e_rv      = 1'b0;
                started   = 1'b1;
            end else begin
                if (rr && en) win.push_back(sdata);
                e_rv = tick;
                if (tick) close_window();
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (started) begin
                chk("read_a", 64'(bus_a.read), 64'(rr & en & ~rst));
                chk("read_b", 64'(bus_b.read), 64'(rr & en & ~rst));
                chk("rv_a",   64'(rv_a),   64'(e_rv));
                chk("rv_b",   64'(rv_b),   64'(e_rv));
                chk("peak_a", 64'(peak_a), 64'(e_peak));
                chk("peak_b", 64'(peak_b), 64'(e_peak));
                chk("lvl_a",  64'(lvl_a),  64'(e_lvl));
                chk("lvl_b",  64'(lvl_b),  64'(e_lvl));
                chk("cnt_a",  64'(cnt_a),  64'(sat(e_raw_cnt, 15)));
                chk("cnt_b",  64'(cnt_b),  64'(sat(e_raw_cnt, 4)));
                chk("ovf_a",  64'(ovf_a),  64'(ovf_of(15)));
                chk("ovf_b",  64'(ovf_b),  64'(ovf_of(4)));
                for (int c = 0; c < CH; c++) begin
                    chk("zc_a", 64'(zc_a[c*15 +: 15]), 64'(sat(e_raw_zc[c], 15)));
                    chk("zc_b", 64'(zc_b[c*4 +: 4]),   64'(sat(e_raw_zc[c], 4)));
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input logic r, input logic rdy, input logic e, input logic t,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        @(negedge clk);
        rst = r; rr = rdy; en = e; tick = t; sdata = {d1, d0};
    endtask

    task automatic idle_check();
        step(0, 0, 1, 0, '0, '0);
        #3;
    endtask

    initial begin
        rst = 1'b1; rr = 1'b0; en = 1'b0; tick = 1'b0; sdata = '0;

        // reset state, read held off even with ready+enable
        step(1, 1, 1, 0, '0, '0);
        step(1, 1, 1, 1, '0, '0);
        #3;
        chk("rst_read",  64'(bus_a.read), 64'd0);
        chk("rst_peak",  64'(peak_a),     64'd0);
        chk("rst_cnt",   64'(cnt_a),      64'd0);
        chk("rst_rv",    64'(rv_a),       64'd0);

        // 1: alternating ch0, constant loud ch1
        for (int i = 0; i < 10; i++)
            step(0, 1, 1, 0, (i % 2 == 0) ? 24'h100000 : 24'hF00000, 24'h300000);
        step(0, 0, 1, 1, '0, '0);
        idle_check();
        chk("t1_rv",    64'(rv_a),          64'd1);
        chk("t1_cnt",   64'(cnt_a),         64'd10);
        chk("t1_pk0",   64'(peak_a[23:0]),  64'h100000);
        chk("t1_zc0",   64'(zc_a[14:0]),    64'd9);
        chk("t1_lv0",   64'(lvl_a[1:0]),    64'd1);
        chk("t1_pk1",   64'(peak_a[47:24]), 64'h300000);
        chk("t1_zc1",   64'(zc_a[29:15]),   64'd0);
        chk("t1_lv1",   64'(lvl_a[3:2]),    64'd3);

        // 2: most negative sample saturates
        step(0, 1, 1, 0, 24'h800000, '0);
        step(0, 0, 1, 1, '0, '0);
        idle_check();
        chk("t2_pk0",   64'(peak_a[23:0]),  64'h7FFFFF);
        chk("t2_lv0",   64'(lvl_a[1:0]),    64'd3);

        // 3: tick coincident with 5th accept, then 3 accepts
        for (int i = 1; i <= 4; i++) step(0, 1, 1, 0, 24'(i * 16), '0);
        step(0, 1, 1, 1, 24'h50, '0);
        idle_check();
        chk("t3_cnt5",  64'(cnt_a),         64'd5);
        for (int i = 1; i <= 3; i++) step(0, 1, 1, 0, 24'(i * 32), '0);
        step(0, 0, 1, 1, '0, '0);
        idle_check();
        chk("t3_cnt3",  64'(cnt_a),         64'd3);

        // 4: saturation in the CNT_W=4 instance
        for (int i = 0; i < 20; i++)
            step(0, 1, 1, 0, (i % 2 == 0) ? 24'h001000 : 24'hFFF000,
                             (i % 2 == 0) ? 24'hFFF000 : 24'h001000);
        step(0, 0, 1, 1, '0, '0);
        idle_check();
        chk("t4_cnt_b", 64'(cnt_b),         64'd15);
        chk("t4_zc_b",  64'(zc_b[3:0]),     64'd15);
        chk("t4_ovf_b", 64'(ovf_b),         64'd1);
        chk("t4_cnt_a", 64'(cnt_a),         64'd20);
        chk("t4_zc_a",  64'(zc_a[14:0]),    64'd19);
        step(0, 0, 1, 1, '0, '0);
        idle_check();
        chk("t4_ovf_e", 64'(ovf_b),         64'd0);
        chk("t4_cnt_e", 64'(cnt_b),         64'd0);

        // 5: enable low blocks accepts, ticks still report
        for (int i = 0; i < 50; i++) begin
            step(0, 1, 0, 0, 24'h7FFFFF, 24'h7FFFFF);
            #3;
            chk("t5_read", 64'(bus_a.read), 64'd0);
        end
        step(0, 1, 0, 1, 24'h7FFFFF, 24'h7FFFFF);
        idle_check();
        chk("t5_rv",    64'(rv_a),          64'd1);
        chk("t5_cnt",   64'(cnt_a),         64'd0);
        chk("t5_peak",  64'(peak_a),        64'd0);
        chk("t5_lvl",   64'(lvl_a),         64'd0);

        // 6: reset mid-window coincident with tick
        for (int i = 0; i < 7; i++)
            step(0, 1, 1, 0, (i % 2 == 0) ? 24'h002000 : 24'hFFE000, 24'h002000);
        step(1, 1, 1, 1, 24'h002000, '0);
        step(1, 0, 1, 0, '0, '0);
        #3;
        chk("t6_rv_rst", 64'(rv_a),         64'd0);
        chk("t6_cnt_rst", 64'(cnt_a),       64'd0);
        step(0, 1, 1, 0, 24'h000001, 24'h000001);
        step(0, 1, 1, 0, 24'hFFFFFF, 24'hFFFFFF);
        step(0, 0, 1, 1, '0, '0);
        idle_check();
        chk("t6_rv",    64'(rv_a),          64'd1);
        chk("t6_cnt",   64'(cnt_a),         64'd2);
        chk("t6_zc0",   64'(zc_a[14:0]),    64'd1);

        // 7: back-to-back ticks, second window empty
        step(0, 1, 1, 0, 24'h400000, 24'h400000);
        step(0, 0, 1, 1, '0, '0);
        step(0, 0, 1, 1, '0, '0);
        idle_check();
        chk("t7_rv",    64'(rv_a),          64'd1);
        chk("t7_cnt",   64'(cnt_a),         64'd0);
        chk("t7_peak",  64'(peak_a),        64'd0);

        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, '0, '0);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
